ttl_74f646: RTL and testbench
=============================

TTL_74F646 -- requirements
Module: ttl_74F646

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of each bus port and each storage register.
REQ-002 SHALL have port CLK  input  1  system clock; all storage updates occur on its rising edge.
REQ-003 SHALL have port RESET  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port A  inout  WIDTH  bus port A, bit 0 = device pin A1.
REQ-005 SHALL have port B  inout  WIDTH  bus port B, bit 0 = device pin B1.
REQ-006 SHALL have port CPAB  input  1  A-register capture strobe, synchronous to CLK.
REQ-007 SHALL have port CPBA  input  1  B-register capture strobe, synchronous to CLK.
REQ-008 SHALL have port SAB  input  1  B-side source select: 0 = real-time A, 1 = stored A register.
REQ-009 SHALL have port SBA  input  1  A-side source select: 0 = real-time B, 1 = stored B register.
REQ-010 SHALL have port DIR  input  1  direction: 1 = drive B, 0 = drive A.
REQ-011 SHALL have port G_N  input  1  output enable, active low.

Function
REQ-012 SHALL hold internal registers AREG[WIDTH], BREG[WIDTH], cpab_q, cpba_q.
REQ-013 SHALL sample CPAB into cpab_q and CPBA into cpba_q on every rising CLK edge.
REQ-014 SHALL treat a rising CLK edge where CPAB=1 and cpab_q=0 as an A-capture event; AREG <= A at that edge.
REQ-015 SHALL treat a rising CLK edge where CPBA=1 and cpba_q=0 as a B-capture event; BREG <= B at that edge.
REQ-016 SHALL capture exactly once per strobe high period; strobe held high across N edges gives one capture.
REQ-017 SHALL update AREG and BREG independently of G_N, DIR, SAB and SBA.
REQ-018 SHALL, with G_N=1, drive both A and B to high-impedance on all bits.
REQ-019 SHALL, with G_N=0 and DIR=1, drive B from A when SAB=0 or from AREG when SAB=1; A stays high-impedance.
REQ-020 SHALL, with G_N=0 and DIR=0, drive A from B when SBA=0 or from BREG when SBA=1; B stays high-impedance.
REQ-021 SHALL implement real-time paths (SAB=0, SBA=0) combinationally, with zero CLK latency.
REQ-022 SHALL make a newly captured register value visible on the driven port immediately after the capturing edge (latency 1 edge from strobe sample).
REQ-023 SHALL, on simultaneous A- and B-capture events, perform both captures at the same edge, each using pre-edge port values.
REQ-024 SHALL, when DIR=1, SAB=1, G_N=0 and a B-capture occurs, load BREG with the pre-edge AREG value, including when an A-capture occurs at the same edge.
REQ-025 SHALL ignore SAB while DIR=0 and SBA while DIR=1.

Reset
REQ-026 SHALL, while RESET=1, force AREG=0 and BREG=0 immediately, independent of CLK.
REQ-027 SHALL, while RESET=1, force cpab_q=1 and cpba_q=1, so a strobe held high through reset release causes no capture.
REQ-028 SHALL keep port drive purely a function of G_N/DIR/SAB/SBA during reset; with SAB=1 or SBA=1 the driven port shows 0.
REQ-029 SHALL, if RESET asserts mid-operation, discard any pending capture; the first capture after release needs a low-then-high strobe.

Verification
REQ-030 SHALL pass: drive A=8'hA5, pulse CPAB 0->1 for one cycle, then DIR=1, SAB=1, G_N=0, A=8'h00 -> B reads 8'hA5, A reads Z.
REQ-031 SHALL pass: drive B=8'h3C, hold CPBA high 5 cycles while B changes to 8'hFF after cycle 1, then DIR=0, SBA=1, G_N=0 -> A reads 8'h3C.
REQ-032 SHALL pass: G_N=1 with any DIR/SAB/SBA -> A and B both Z; capture of A=8'h11 via CPAB still occurs and later shows on B with SAB=1.
REQ-033 SHALL pass: DIR=1, SAB=0, G_N=0, A toggled 8'h55/8'hAA each cycle -> B follows A with no cycle delay.
REQ-034 SHALL pass: AREG=8'h77, DIR=1, SAB=1, G_N=0, CPAB and CPBA rise together with A=8'h99 -> after edge AREG=8'h99, BREG=8'h77, B reads 8'h99.
REQ-035 SHALL pass: AREG=8'hC3, CPAB held high, assert RESET for 2 cycles mid-clock, release with CPAB still high -> AREG=8'h00 asynchronously and remains 8'h00 until CPAB goes low then high.

Source files
------------

// File: rtl/ttl_74f646.sv
// Octal bus transceiver/register: two edge-captured registers (AREG, BREG) plus
// bidirectional real-time or stored-data transfer between ports A and B.
module ttl_74f646 #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    inout  wire  [WIDTH-1:0] A,
    inout  wire  [WIDTH-1:0] B,
    input  logic             CPAB,
    input  logic             CPBA,
    input  logic             SAB,
    input  logic             SBA,
    input  logic             DIR,
    input  logic             G_N
);

    logic             drive_a;
    logic             drive_b;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] areg_q;
    logic [WIDTH-1:0] areg_d;
    logic [WIDTH-1:0] breg_q;
    logic [WIDTH-1:0] breg_d;
    logic             cpab_q;
    logic             cpba_q;

    always_comb begin
        drive_b = !G_N && DIR;
        drive_a = !G_N && !DIR;
        b_out   = SAB ? areg_q : A;
        a_out   = SBA ? breg_q : B;
        // Capture what is on the pin pre-edge; when we drive it, that is our own output.
        a_in    = drive_a ? a_out : A;
        b_in    = drive_b ? b_out : B;
    end

    always_comb begin
        areg_d = areg_q;
        breg_d = breg_q;
        if (CPAB && !cpab_q) areg_d = a_in;
        if (CPBA && !cpba_q) breg_d = b_in;
    end

    // Strobe history resets high so a strobe held through reset release cannot capture.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            areg_q <= '0;
            breg_q <= '0;
            cpab_q <= 1'b1;
            cpba_q <= 1'b1;
        end else begin
            areg_q <= areg_d;
            breg_q <= breg_d;
            cpab_q <= CPAB;
            cpba_q <= CPBA;
        end
    end

    assign A = drive_a ? a_out : {WIDTH{1'bz}};
    assign B = drive_b ? b_out : {WIDTH{1'bz}};

endmodule

// File: tb/tb_ttl_74f646.sv
// Bench for ttl_74f646: directed vector table, reset corner sequence, and
// randomized traffic checked against a register-level behavioural model.
module tb_ttl_74f646;

    logic       clk = 1'b0;
    logic       rst;
    logic       g_n, dir, sab, sba, cpab, cpba, a_en, b_en;
    logic [7:0] ta, tbv;
    wire  [7:0] a_bus;
    wire  [7:0] b_bus;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Undriven bus bits read back as 1 so high-impedance is observable.
    assign a_bus = a_en ? ta  : 8'hzz;
    assign b_bus = b_en ? tbv : 8'hzz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (a_bus[i]);
        pullup (b_bus[i]);
    end

    always #5 clk = ~clk;

    ttl_74f646 #(.WIDTH(8)) dut (
        .CLK(clk), .RESET(rst), .A(a_bus), .B(b_bus),
        .CPAB(cpab), .CPBA(cpba), .SAB(sab), .SBA(sba), .DIR(dir), .G_N(g_n)
    );

    // Reference model state: stored bytes and strobe level seen at the last edge.
    logic [7:0] m_areg, m_breg;
    logic       m_pa, m_pb;

    function automatic logic [7:0] ext_a();
        return a_en ? ta : 8'hFF;
    endfunction
    function automatic logic [7:0] ext_b();
        return b_en ? tbv : 8'hFF;
    endfunction
    function automatic logic [7:0] exp_a();
        if (!g_n && !dir) return sba ? m_breg : ext_b();
        return ext_a();
    endfunction
    function automatic logic [7:0] exp_b();
        if (!g_n && dir) return sab ? m_areg : ext_a();
        return ext_b();
    endfunction

    task automatic model_reset();
        m_areg = 8'h00;
        m_breg = 8'h00;
        m_pa   = 1'b1;
        m_pb   = 1'b1;
    endtask

    task automatic model_edge();
        logic [7:0] sa, sb;
        sa = exp_a();
        sb = exp_b();
        if (!rst) begin
            if (cpab && !m_pa) m_areg = sa;
            if (cpba && !m_pb) m_breg = sb;
            m_pa = cpab;
            m_pb = cpba;
        end
    endtask

    task automatic check(input string name, input logic [7:0] ea, input logic [7:0] eb);
        vec_cnt++;
        if (a_bus !== ea || b_bus !== eb) begin
            err_cnt++;
            $display("FAIL %s: got A=%h B=%h, expected A=%h B=%h", name, a_bus, b_bus, ea, eb);
        end
    endtask

    typedef struct {
        logic       g_n, dir, sab, sba, cpab, cpba, a_en, b_en;
        logic [7:0] a, b, ea, eb;
    } vec_t;

    function automatic vec_t mk(logic gn, logic d, logic sa, logic sb, logic pa, logic pb,
                                logic ae, logic [7:0] av, logic be, logic [7:0] bv,
                                logic [7:0] ea, logic [7:0] eb);
        vec_t v;
        v.g_n = gn; v.dir = d; v.sab = sa; v.sba = sb; v.cpab = pa; v.cpba = pb;
        v.a_en = ae; v.a = av; v.b_en = be; v.b = bv; v.ea = ea; v.eb = eb;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        // gn dir sab sba cpab cpba | a_en a | b_en b | expected A B (post-edge)
        tbl.push_back(mk(1,1,0,0,0,0, 1,8'hA5, 0,8'h00, 8'hA5,8'hFF));
        tbl.push_back(mk(1,1,0,0,1,0, 1,8'hA5, 0,8'h00, 8'hA5,8'hFF));
        tbl.push_back(mk(0,1,1,0,0,0, 1,8'h00, 0,8'h00, 8'h00,8'hA5));
        tbl.push_back(mk(0,1,0,0,0,0, 1,8'h55, 0,8'h00, 8'h55,8'h55));
        tbl.push_back(mk(0,1,0,0,0,0, 1,8'hAA, 0,8'h00, 8'hAA,8'hAA));
        tbl.push_back(mk(1,0,0,0,0,0, 0,8'h00, 1,8'h3C, 8'hFF,8'h3C));
        tbl.push_back(mk(1,0,0,0,0,1, 0,8'h00, 1,8'h3C, 8'hFF,8'h3C));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1,0,0,0,0,1, 0,8'h00, 1,8'hFF, 8'hFF,8'hFF));
        tbl.push_back(mk(0,0,0,1,0,0, 0,8'h00, 1,8'hFF, 8'h3C,8'hFF));
        tbl.push_back(mk(1,0,0,1,1,0, 1,8'h11, 0,8'h00, 8'h11,8'hFF));
        tbl.push_back(mk(0,1,1,0,0,0, 1,8'h00, 0,8'h00, 8'h00,8'h11));
        tbl.push_back(mk(0,1,1,0,1,0, 1,8'h77, 0,8'h00, 8'h77,8'h77));
        tbl.push_back(mk(0,1,1,0,0,0, 1,8'h77, 0,8'h00, 8'h77,8'h77));
        tbl.push_back(mk(0,1,1,0,1,1, 1,8'h99, 0,8'h00, 8'h99,8'h99));
        tbl.push_back(mk(0,0,0,1,0,0, 0,8'h00, 1,8'h00, 8'h77,8'h00));
        tbl.push_back(mk(0,0,1,0,0,0, 0,8'h00, 1,8'hE1, 8'hE1,8'hE1));
        tbl.push_back(mk(0,1,0,1,0,0, 1,8'h3D, 0,8'h00, 8'h3D,8'h3D));

        // Reset state and port drive during reset
        rst = 1'b1; g_n = 1'b1; dir = 1'b0; sab = 1'b0; sba = 1'b0;
        cpab = 1'b0; cpba = 1'b0; a_en = 1'b0; b_en = 1'b0; ta = 8'h00; tbv = 8'h00;
        #2 check("rst_z", 8'hFF, 8'hFF);
        g_n = 1'b0; dir = 1'b1; sab = 1'b1; a_en = 1'b1; ta = 8'h5A;
        #1 check("rst_areg", 8'h5A, 8'h00);
        dir = 1'b0; sba = 1'b1; a_en = 1'b0; b_en = 1'b1; tbv = 8'hC7;
        #1 check("rst_breg", 8'h00, 8'hC7);
        @(negedge clk); rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            g_n = tbl[i].g_n; dir = tbl[i].dir; sab = tbl[i].sab; sba = tbl[i].sba;
            cpab = tbl[i].cpab; cpba = tbl[i].cpba;
            a_en = tbl[i].a_en; ta = tbl[i].a; b_en = tbl[i].b_en; tbv = tbl[i].b;
            @(posedge clk); #1;
            check($sformatf("tbl%0d", i), tbl[i].ea, tbl[i].eb);
        end

        // Reset mid-operation with CPAB held high across release
        @(negedge clk);
        g_n = 1'b0; dir = 1'b1; sab = 1'b1; sba = 1'b0; a_en = 1'b1; ta = 8'hC3;
        b_en = 1'b0; cpab = 1'b0; cpba = 1'b0;
        @(posedge clk); #1 check("r_pre", 8'hC3, 8'h99);
        @(negedge clk); cpab = 1'b1;
        @(posedge clk); #1 check("r_cap", 8'hC3, 8'hC3);
        @(negedge clk); #2 rst = 1'b1;
        #1 check("r_async", 8'hC3, 8'h00);
        repeat (2) begin
            @(posedge clk); #1 check("r_hold", 8'hC3, 8'h00);
        end
        @(negedge clk); #2 rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #1 check("r_nocap", 8'hC3, 8'h00);
        end
        @(negedge clk); cpab = 1'b0;
        @(posedge clk); #1 check("r_low", 8'hC3, 8'h00);
        @(negedge clk); cpab = 1'b1;
        @(posedge clk); #1 check("r_recap", 8'hC3, 8'hC3);

        // Randomized traffic against the model
        @(negedge clk); rst = 1'b1; model_reset();
        @(negedge clk); rst = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (rst) begin
                if ($urandom_range(0, 2) == 0) rst = 1'b0;
            end else if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                model_reset();
            end
            g_n = ($urandom_range(0, 3) == 0);
            dir = 1'($urandom_range(0, 1));
            sab = 1'($urandom_range(0, 1));
            sba = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) cpab = ~cpab;
            if ($urandom_range(0, 2) == 0) cpba = ~cpba;
            ta   = 8'($urandom);
            tbv  = 8'($urandom);
            a_en = !(!g_n && !dir) && ($urandom_range(0, 7) != 0);
            b_en = !(!g_n && dir) && ($urandom_range(0, 7) != 0);
            #1 check("rnd_comb", exp_a(), exp_b());
            @(posedge clk);
            model_edge();
            #1 check("rnd_edge", exp_a(), exp_b());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
